// File: rtl/adc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : adc_uart_tx
// Brief   : Snapshots four 16-bit ADC samples and sends them as 12 UART bytes
//           (header 0x90|N, MSB, LSB for N = 0..3), 8E1 framing plus idle gap.
// Revision: 1.0 - initial release
// ============================================================================
module adc_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tx,
  input  logic [15:0] adc_din0,
  input  logic [15:0] adc_din1,
  input  logic [15:0] adc_din2,
  input  logic [15:0] adc_din3,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic [15:0] counter_bursts_sent,
  output logic [15:0] counter_start_ignored
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         c_gap_last = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [1:0]         c_sel_hdr  = 2'd0;
  localparam logic [1:0]         c_sel_msb  = 2'd1;
  localparam logic [1:0]         c_sel_lsb  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               r_state;
  logic [15:0]          r_din [0:3];
  logic [7:0]           r_shift;
  logic                 r_par;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_bit;
  logic [3:0]           r_gap;
  logic [1:0]           r_pkt;
  logic [1:0]           r_sel;

  logic                 w_bit_end;
  logic                 w_last_byte;
  logic                 w_byte_done;
  logic [1:0]           w_nxt_sel;
  logic [1:0]           w_nxt_pkt;
  logic [7:0]           w_nxt_byte;

  assign w_bit_end   = (r_cnt == c_cnt_last);
  assign w_last_byte = (r_pkt == 2'd3) && (r_sel == c_sel_lsb);
  assign w_nxt_sel   = (r_sel == c_sel_lsb) ? c_sel_hdr : r_sel + 2'd1;
  assign w_nxt_pkt   = (r_sel == c_sel_lsb) ? r_pkt + 2'd1 : r_pkt;

  // A byte (including its trailing gap) ends either at the stop bit or at the last gap bit.
  assign w_byte_done = w_bit_end &&
                       (((r_state == S_STOP) && (GAP_BITS == 0)) ||
                        ((r_state == S_GAP) && (r_gap == c_gap_last)));

  always_comb begin
    w_nxt_byte = r_din[w_nxt_pkt][7:0];
    case (w_nxt_sel)
      c_sel_hdr: w_nxt_byte = {6'b100100, w_nxt_pkt};
      c_sel_msb: w_nxt_byte = r_din[w_nxt_pkt][15:8];
      default:   w_nxt_byte = r_din[w_nxt_pkt][7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state               <= S_IDLE;
      r_din[0]              <= 16'h0000;
      r_din[1]              <= 16'h0000;
      r_din[2]              <= 16'h0000;
      r_din[3]              <= 16'h0000;
      r_shift               <= 8'h00;
      r_par                 <= 1'b0;
      r_cnt                 <= '0;
      r_bit                 <= 3'd0;
      r_gap                 <= 4'd0;
      r_pkt                 <= 2'd0;
      r_sel                 <= c_sel_hdr;
      dout                  <= 1'b1;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      counter_bursts_sent   <= 16'h0000;
      counter_start_ignored <= 16'h0000;
    end else begin
      if (start_tx && (r_state != S_IDLE))
        counter_start_ignored <= counter_start_ignored + 16'd1;

      if ((r_state == S_IDLE) || (r_state == S_DONE))
        r_cnt <= '0;
      else
        r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          dout <= 1'b1;
          done <= 1'b0;
          if (start_tx) begin
            r_din[0] <= adc_din0;
            r_din[1] <= adc_din1;
            r_din[2] <= adc_din2;
            r_din[3] <= adc_din3;
            r_shift  <= 8'h90;
            r_par    <= ^8'h90;
            r_pkt    <= 2'd0;
            r_sel    <= c_sel_hdr;
            busy     <= 1'b1;
            dout     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            dout    <= r_shift[0];
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              dout    <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              dout    <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            dout    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end && (GAP_BITS != 0)) begin
            r_gap   <= 4'd0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_bit_end)
            r_gap <= r_gap + 4'd1;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          dout    <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      // Chain straight into the next byte's start bit, or close out the burst.
      if (w_byte_done) begin
        if (w_last_byte) begin
          dout                <= 1'b1;
          busy                <= 1'b0;
          done                <= 1'b1;
          counter_bursts_sent <= counter_bursts_sent + 16'd1;
          r_state             <= S_DONE;
        end else begin
          r_shift <= w_nxt_byte;
          r_par   <= ^w_nxt_byte;
          r_sel   <= w_nxt_sel;
          r_pkt   <= w_nxt_pkt;
          dout    <= 1'b0;
          r_state <= S_START;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_uart_tx
// Brief   : Directed self-checking bench for adc_uart_tx (CLKS_PER_BIT=4, GAP_BITS=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_uart_tx;

  localparam int c_burst_cyc = 577;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tx = 1'b0;
  logic [15:0] adc_din0 = 16'h0000;
  logic [15:0] adc_din1 = 16'h0000;
  logic [15:0] adc_din2 = 16'h0000;
  logic [15:0] adc_din3 = 16'h0000;
  logic        dout;
  logic        busy;
  logic        done;
  logic [15:0] counter_bursts_sent;
  logic [15:0] counter_start_ignored;

  int   n_checks = 0;
  int   n_fail = 0;
  logic line_q [0:600];
  logic done_q [0:600];

  always #5 clk = ~clk;

  adc_uart_tx #(.CLKS_PER_BIT(4), .GAP_BITS(1)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start_tx              (start_tx),
    .adc_din0              (adc_din0),
    .adc_din1              (adc_din1),
    .adc_din2              (adc_din2),
    .adc_din3              (adc_din3),
    .dout                  (dout),
    .busy                  (busy),
    .done                  (done),
    .counter_bursts_sent   (counter_bursts_sent),
    .counter_start_ignored (counter_start_ignored)
  );

  // Time-ordered line bits: start, d0..d7, parity, stop, one gap bit.
  function automatic logic [11:0] frame_of(input logic [7:0] b, input logic p);
    frame_of = {1'b1, 1'b1, p, b, 1'b0};
  endfunction

  function automatic logic [7:0] byte_of(input logic [15:0] d0, input logic [15:0] d1,
                                         input logic [15:0] d2, input logic [15:0] d3,
                                         input int idx);
    logic [15:0] w;
    int pkt;
    pkt = idx / 3;
    case (pkt)
      0: w = d0;
      1: w = d1;
      2: w = d2;
      default: w = d3;
    endcase
    case (idx % 3)
      0: byte_of = 8'h90 | 8'(pkt);
      1: byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  function automatic logic [11:0] par_of(input logic [15:0] d0, input logic [15:0] d1,
                                         input logic [15:0] d2, input logic [15:0] d3);
    logic [7:0] b;
    par_of = 12'h000;
    for (int i = 0; i < 12; i++) begin
      b = byte_of(d0, d1, d2, d3, i);
      par_of[i] = ^b;
    end
  endfunction

  // Sends one burst starting at the next cycle and checks every bit time on the line.
  task automatic run_burst(input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic [11:0] par, input bit chg100,
                           input bit pulse50, input bit pulse_done);
    logic        busy_at1;
    logic [11:0] obs;
    logic [11:0] exp_f;
    bit          bad;
    bit          early;
    int          base;
    @(posedge clk); #1;
    adc_din0 = d0; adc_din1 = d1; adc_din2 = d2; adc_din3 = d3;
    start_tx = 1'b1;
    busy_at1 = 1'b0;
    for (int k = 1; k <= c_burst_cyc; k++) begin
      @(posedge clk); #1;
      start_tx = (pulse50 && k == 50) || (pulse_done && k == c_burst_cyc);
      if (chg100 && k == 100) begin
        adc_din0 = 16'h5555; adc_din1 = 16'h5555; adc_din2 = 16'h5555; adc_din3 = 16'h5555;
      end
      line_q[k] = dout;
      done_q[k] = done;
      if (k == 1) busy_at1 = busy;
    end
    n_checks++;
    if (busy_at1 !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b exp 1", busy_at1);
    end
    early = 1'b0;
    for (int k = 1; k < c_burst_cyc; k++) if (done_q[k] !== 1'b0) early = 1'b1;
    n_checks++;
    if (early || done_q[c_burst_cyc] !== 1'b1) begin
      n_fail++; $display("FAIL done_latency: early=%0d done@T+577=%b exp early=0 done=1",
                         early, done_q[c_burst_cyc]);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_at_done: got %b exp 0", busy);
    end
    for (int b = 0; b < 12; b++) begin
      base = 1 + b * 48;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
        obs[i] = line_q[base + 4 * i];
        for (int s = 1; s < 4; s++)
          if (line_q[base + 4 * i + s] !== obs[i]) bad = 1'b1;
      end
      exp_f = frame_of(byte_of(d0, d1, d2, d3, b), par[b]);
      n_checks++;
      if (bad || obs !== exp_f) begin
        n_fail++; $display("FAIL frame_byte%0d: got %h (unstable=%0d) exp %h", b, obs, bad, exp_f);
      end
    end
  endtask

  task automatic test_reset;
    bit bad;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: dout=%b busy=%b done=%b exp 1 0 0", dout, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL idle_line: got disturbance=1 exp 0");
    end
    n_checks++;
    if (counter_bursts_sent !== 16'h0 || counter_start_ignored !== 16'h0) begin
      n_fail++; $display("FAIL reset_counters: sent=%h ign=%h exp 0 0",
                         counter_bursts_sent, counter_start_ignored);
    end
  endtask

  task automatic test_basic;
    // Hand-computed even parity for 90 12 34 91 AB CD 92 00 00 93 FF FF
    run_burst(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 12'h07C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (counter_bursts_sent !== 16'd1) begin
      n_fail++; $display("FAIL bursts_after_basic: got %0d exp 1", counter_bursts_sent);
    end
  endtask

  task automatic test_snapshot;
    run_burst(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 12'h07C, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (counter_bursts_sent !== 16'd2) begin
      n_fail++; $display("FAIL bursts_after_snapshot: got %0d exp 2", counter_bursts_sent);
    end
  endtask

  task automatic test_ignore;
    run_burst(16'h0F0F, 16'h8001, 16'h7E42, 16'h00FF,
              par_of(16'h0F0F, 16'h8001, 16'h7E42, 16'h00FF), 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (counter_start_ignored !== 16'd1) begin
      n_fail++; $display("FAIL ignored_mid_burst: got %0d exp 1", counter_start_ignored);
    end
    run_burst(16'hC3A5, 16'h1111, 16'h2468, 16'hFEDC,
              par_of(16'hC3A5, 16'h1111, 16'h2468, 16'hFEDC), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (counter_start_ignored !== 16'd2) begin
      n_fail++; $display("FAIL ignored_total: got %0d exp 2", counter_start_ignored);
    end
    n_checks++;
    if (counter_bursts_sent !== 16'd4) begin
      n_fail++; $display("FAIL bursts_after_ignore: got %0d exp 4", counter_bursts_sent);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    adc_din0 = 16'h1234; adc_din1 = 16'hABCD; adc_din2 = 16'h0000; adc_din3 = 16'hFFFF;
    start_tx = 1'b1;
    // Cycle T+206 falls in data bit 2 of byte 5 (0xAB), which is a 0 on the line.
    for (int k = 1; k <= 206; k++) begin
      @(posedge clk); #1;
      start_tx = 1'b0;
    end
    n_checks++;
    if (dout !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: dout=%b busy=%b exp 0 1", dout, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: dout=%b busy=%b done=%b exp 1 0 0", dout, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (counter_bursts_sent !== 16'h0 || counter_start_ignored !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_counters: sent=%h ign=%h exp 0 0",
                         counter_bursts_sent, counter_start_ignored);
    end
    @(negedge clk); rst_n = 1'b1;
    run_burst(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 12'h07C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (counter_bursts_sent !== 16'd1) begin
      n_fail++; $display("FAIL bursts_after_reset: got %0d exp 1", counter_bursts_sent);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] tbl [0:19];
    tbl = '{16'h0001, 16'h8000, 16'hAAAA, 16'h5555,
            16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D,
            16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00,
            16'h1357, 16'h2468, 16'h9ABC, 16'hEF01,
            16'h7FFF, 16'h8001, 16'h3C3C, 16'hC3C3};
    for (int i = 0; i < 5; i++)
      run_burst(tbl[4*i], tbl[4*i+1], tbl[4*i+2], tbl[4*i+3],
                par_of(tbl[4*i], tbl[4*i+1], tbl[4*i+2], tbl[4*i+3]), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (counter_bursts_sent !== 16'd6 || counter_start_ignored !== 16'd0) begin
      n_fail++; $display("FAIL back_to_back_counters: sent=%0d ign=%0d exp 6 0",
                         counter_bursts_sent, counter_start_ignored);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_snapshot;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
